// File: rtl/floo_wormhole_arbiter_pkg.sv
// floo_wormhole_arbiter_pkg
// Flit typedefs shared by the wormhole arbiter and its users. A flit carries a
// small header whose `last` bit closes a packet, followed by an opaque payload.
package floo_wormhole_arbiter_pkg;

  localparam int unsigned DstIdWidth       = 4;
  localparam int unsigned FlitPayloadWidth = 16;

  typedef struct packed {
    logic                  last;
    logic [DstIdWidth-1:0] dst_id;
  } floo_hdr_t;

  typedef struct packed {
    floo_hdr_t                   hdr;
    logic [FlitPayloadWidth-1:0] payload;
  } floo_flit_t;

endpackage

// File: rtl/floo_wormhole_arbiter_lzc.sv
// floo_wormhole_arbiter_lzc
// Trailing-zero counter: reports the index of the lowest set bit of in_i.
//   in_i    : request vector (bit 0 has the highest priority)
//   cnt_o   : index of the lowest set bit ('0 when empty)
//   empty_o : no bit of in_i is set
module floo_wormhole_arbiter_lzc #(
  parameter int unsigned Width    = 2,
  parameter int unsigned CntWidth = $clog2(Width)
) (
  input  logic [Width-1:0]    in_i,
  output logic [CntWidth-1:0] cnt_o,
  output logic                empty_o
);

  // Scan from the top down so the lowest set bit is written last and wins.
  always_comb begin
    cnt_o   = '0;
    empty_o = 1'b1;
    for (int unsigned i = 0; i < Width; i++) begin
      if (in_i[CntWidth'(Width - 1 - i)]) begin
        cnt_o   = CntWidth'(Width - 1 - i);
        empty_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/floo_wormhole_arbiter.sv
// floo_wormhole_arbiter
// Shares one flit output among NumInputs inputs at packet granularity. An idle
// arbiter picks the first valid input at or above the round-robin pointer; once
// a flit is offered without completing a packet the grant is locked until the
// flit with hdr.last=1 is accepted.
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset
//   valid_i : per-input flit valid
//   ready_o : per-input flit accepted (only the granted input sees ready_i)
//   data_i  : per-input flit
//   valid_o : output flit valid
//   ready_i : downstream ready
//   data_o  : granted input's flit
//   grant_o : index of the granted input (meaningful while valid_o=1)
module floo_wormhole_arbiter
  import floo_wormhole_arbiter_pkg::*;
#(
  parameter int unsigned NumInputs = 2,
  parameter type         flit_t    = floo_flit_t,
  parameter int unsigned SelWidth  = $clog2(NumInputs)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NumInputs-1:0] valid_i,
  output logic [NumInputs-1:0] ready_o,
  input  flit_t                data_i [NumInputs],
  output logic                 valid_o,
  input  logic                 ready_i,
  output flit_t                data_o,
  output logic [SelWidth-1:0]  grant_o
);

  typedef enum logic {
    StIdle,
    StLocked
  } state_e;

  state_e                state_q, state_d;
  logic [SelWidth-1:0]   grant_q, grant_d;
  logic [SelWidth-1:0]   rr_q, rr_d;

  logic [NumInputs-1:0]  valid_rot;
  logic [SelWidth-1:0]   lzc_cnt;
  logic                  lzc_empty;
  logic [SelWidth-1:0]   arb_idx;
  logic [SelWidth-1:0]   grant;
  logic                  handshake;
  logic                  last_flit;

  // Rotate the request vector so that input rr_q lands on bit 0; the lowest set
  // bit of the rotated vector is then the first requester at or above rr_q.
  always_comb begin
    valid_rot = '0;
    for (int unsigned i = 0; i < NumInputs; i++) begin
      valid_rot[SelWidth'(i)] = valid_i[SelWidth'((i + 32'(rr_q)) % NumInputs)];
    end
  end

  floo_wormhole_arbiter_lzc #(
    .Width    (NumInputs),
    .CntWidth (SelWidth)
  ) i_lzc (
    .in_i    (valid_rot),
    .cnt_o   (lzc_cnt),
    .empty_o (lzc_empty)
  );

  always_comb begin
    arb_idx = rr_q;
    if (!lzc_empty) begin
      arb_idx = SelWidth'((32'(rr_q) + 32'(lzc_cnt)) % NumInputs);
    end
  end

  // Output side: depends only on state and valid_i, never on ready_i.
  always_comb begin
    if (state_q == StLocked) begin
      grant   = grant_q;
      valid_o = valid_i[grant_q];
    end else begin
      grant   = arb_idx;
      valid_o = |valid_i;
    end
    data_o  = data_i[grant];
    grant_o = grant;
    ready_o = '0;
    if (valid_o) begin
      ready_o[grant] = ready_i;
    end
  end

  assign handshake = valid_o & ready_i;
  assign last_flit = data_o.hdr.last;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    if (handshake && last_flit) begin
      state_d = StIdle;
      rr_d    = (grant == SelWidth'(NumInputs - 1)) ? '0 : grant + SelWidth'(1);
    end else if (valid_o && (state_q == StIdle)) begin
      // A stalled head flit locks too, so the offered flit cannot be swapped.
      state_d = StLocked;
      grant_d = grant;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      grant_q <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
    end
  end

  // Upstream must hold an offered flit stable until it is accepted.
  data_stable_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (valid_o && !ready_i) |=> (!valid_o || $stable(data_o)));

endmodule

// File: tb/tb_floo_wormhole_arbiter.sv
// tb_floo_wormhole_arbiter
// Directed, table-driven bench for a 4-input wormhole arbiter, plus a
// hand-written sequence for reset asserted in the middle of a locked packet.
module tb_floo_wormhole_arbiter;
  import floo_wormhole_arbiter_pkg::*;

  logic       clk = 1'b0;
  logic       rst_ni = 1'b0;
  logic [3:0] valid_i = '0;
  logic [3:0] ready_o;
  floo_flit_t data_i [4];
  logic       valid_o;
  logic       ready_i = 1'b0;
  floo_flit_t data_o;
  logic [1:0] grant_o;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  floo_wormhole_arbiter #(
    .NumInputs (4),
    .flit_t    (floo_flit_t),
    .SelWidth  (2)
  ) dut (
    .clk_i   (clk),
    .rst_ni  (rst_ni),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_i  (data_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .data_o  (data_o),
    .grant_o (grant_o)
  );

  typedef struct {
    string      name;
    logic [3:0] valid;
    logic       ready;
    logic [3:0] last;
    logic [7:0] tag;
    logic       exp_valid;
    logic [3:0] exp_ready;
    logic [1:0] exp_grant;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string nm, input logic [3:0] v, input logic r,
                     input logic [3:0] l, input logic [7:0] tag,
                     input logic ev, input logic [3:0] er, input logic [1:0] eg);
    vec_t e;
    e.name = nm; e.valid = v; e.ready = r; e.last = l; e.tag = tag;
    e.exp_valid = ev; e.exp_ready = er; e.exp_grant = eg;
    vecs.push_back(e);
  endtask

  // Payload of input i is {tag, i}, so data_o identifies both the vector and the input.
  task automatic apply(input logic [3:0] v, input logic r, input logic [3:0] l,
                       input logic [7:0] tag);
    valid_i = v;
    ready_i = r;
    for (int i = 0; i < 4; i++) begin
      data_i[2'(i)].hdr.last   = l[2'(i)];
      data_i[2'(i)].hdr.dst_id = 4'(i);
      data_i[2'(i)].payload    = {tag, 8'(i)};
    end
  endtask

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", nm, got, exp);
  endtask

  task automatic check_outputs(input string nm, input logic ev, input logic [3:0] er,
                               input logic [1:0] eg, input logic [7:0] tag);
    check({nm, " valid_o"}, 32'(valid_o), 32'(ev));
    check({nm, " ready_o"}, 32'(ready_o), 32'(er));
    check({nm, " grant_o"}, 32'(grant_o), 32'(eg));
    if (ev) check({nm, " data_o"}, 32'(data_o.payload), 32'({tag, 6'd0, eg}));
  endtask

  initial begin
    apply(4'b0000, 1'b0, 4'b0000, 8'h00);

    //   name           valid    rdy   last     tag    ev    ready_o  grant
    add("reset_idle",   4'b0000, 1'b0, 4'b0000, 8'h00, 1'b0, 4'b0000, 2'd0);
    // all four request single-flit packets: round robin 0,1,2,3 then wrap
    add("rr_g0",        4'b1111, 1'b1, 4'b1111, 8'h01, 1'b1, 4'b0001, 2'd0);
    add("rr_g1",        4'b1111, 1'b1, 4'b1111, 8'h02, 1'b1, 4'b0010, 2'd1);
    add("rr_g2",        4'b1111, 1'b1, 4'b1111, 8'h03, 1'b1, 4'b0100, 2'd2);
    add("rr_g3",        4'b1111, 1'b1, 4'b1111, 8'h04, 1'b1, 4'b1000, 2'd3);
    // move pointer to 2, then input 2 sends 3 flits while input 0 waits
    add("solo_in1",     4'b0010, 1'b1, 4'b0010, 8'h05, 1'b1, 4'b0010, 2'd1);
    add("pkt2_f0",      4'b0101, 1'b1, 4'b0001, 8'h06, 1'b1, 4'b0100, 2'd2);
    add("pkt2_f1",      4'b0101, 1'b1, 4'b0001, 8'h07, 1'b1, 4'b0100, 2'd2);
    add("pkt2_f2",      4'b0101, 1'b1, 4'b0101, 8'h08, 1'b1, 4'b0100, 2'd2);
    add("wrap_in0",     4'b0101, 1'b1, 4'b0101, 8'h09, 1'b1, 4'b0001, 2'd0);
    // head flit of input 1 stalled 5 cycles; input 0 joins but is ignored
    add("stall_c1",     4'b0010, 1'b0, 4'b0010, 8'h10, 1'b1, 4'b0000, 2'd1);
    add("stall_c2",     4'b0011, 1'b0, 4'b0011, 8'h10, 1'b1, 4'b0000, 2'd1);
    add("stall_c3",     4'b0011, 1'b0, 4'b0011, 8'h10, 1'b1, 4'b0000, 2'd1);
    add("stall_c4",     4'b0011, 1'b0, 4'b0011, 8'h10, 1'b1, 4'b0000, 2'd1);
    add("stall_c5",     4'b0011, 1'b0, 4'b0011, 8'h10, 1'b1, 4'b0000, 2'd1);
    add("stall_hs",     4'b0011, 1'b1, 4'b0011, 8'h10, 1'b1, 4'b0010, 2'd1);
    // input 3 locked, then drops valid for 2 cycles while others request
    add("lock3_f0",     4'b1000, 1'b1, 4'b0000, 8'h20, 1'b1, 4'b1000, 2'd3);
    add("lock3_gap1",   4'b0111, 1'b1, 4'b0111, 8'h21, 1'b0, 4'b0000, 2'd3);
    add("lock3_gap2",   4'b0111, 1'b1, 4'b0111, 8'h22, 1'b0, 4'b0000, 2'd3);
    add("lock3_last",   4'b1111, 1'b1, 4'b1000, 8'h23, 1'b1, 4'b1000, 2'd3);

    repeat (2) @(negedge clk);
    #1 check_outputs("in_reset", 1'b0, 4'b0000, 2'd0, 8'h00);
    @(negedge clk);
    rst_ni = 1'b1;

    foreach (vecs[k]) begin
      @(negedge clk);
      apply(vecs[k].valid, vecs[k].ready, vecs[k].last, vecs[k].tag);
      #1 check_outputs(vecs[k].name, vecs[k].exp_valid, vecs[k].exp_ready,
                       vecs[k].exp_grant, vecs[k].tag);
    end

    // Reset in the middle of a packet on input 1 (pointer is 0 here).
    @(negedge clk);
    apply(4'b0010, 1'b1, 4'b0000, 8'h40);
    #1 check_outputs("rst_pkt_head", 1'b1, 4'b0010, 2'd1, 8'h40);
    @(negedge clk);
    apply(4'b0011, 1'b0, 4'b0000, 8'h40);
    #1 check_outputs("rst_pkt_locked", 1'b1, 4'b0000, 2'd1, 8'h40);
    #1 rst_ni = 1'b0;
    #1 check_outputs("rst_async_drop", 1'b1, 4'b0000, 2'd0, 8'h40);
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    apply(4'b0011, 1'b1, 4'b0011, 8'h41);
    #1 check_outputs("rst_after_in0", 1'b1, 4'b0001, 2'd0, 8'h41);
    @(negedge clk);
    apply(4'b0011, 1'b1, 4'b0011, 8'h42);
    #1 check_outputs("rst_after_in1", 1'b1, 4'b0010, 2'd1, 8'h42);

    @(negedge clk);
    apply(4'b0000, 1'b0, 4'b0000, 8'h00);
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
